risc_run_ctrl: RTL and testbench
================================

# risc_run_ctrl

Synthesisable run controller for the 16-bit RISC core. It replaces the fixed clock-and-finish harness with a parametrised sequencer that:
- holds the core in reset for a programmable number of cycles, then gates the core clock enable;
- supports free-run, pause and single-step;
- stops on a cycle budget or on halt detection (PC stuck).

It sits between the top level (or a debug host) and the core's `clk`/reset/PC pins.

## Interface
Parameters:
- CYCLE_W, 32, width of cycle counter and budget
- PC_W, 16, width of observed program counter
- RESET_CYCLES, 4, cycles core reset is held low per start (>=1)
- HALT_STABLE, 8, consecutive enabled cycles with unchanged PC that declare halt; 0 disables halt detection

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin run (accepted in IDLE or DONE only)
- stop  in  1  pause a free run (RUN only)
- resume  in  1  return from PAUSE to RUN
- step  in  1  one enabled core cycle while in PAUSE
- step_mode  in  1  sampled with start: 1 = enter PAUSE after reset instead of RUN
- max_cycles  in  CYCLE_W  cycle budget, sampled with start; 0 = unlimited
- pc  in  PC_W  core program counter
- cpu_rst_n  out  1  reset to core, active low
- cpu_clk_en  out  1  clock enable to core
- busy  out  1  state is RST, RUN or PAUSE
- done  out  1  state is DONE
- halted  out  1  sticky: run ended by halt detection
- timeout  out  1  sticky: run ended by cycle budget
- cycle_count  out  CYCLE_W  enabled core cycles this run

## Operation
- FSM states: IDLE, RST, RUN, PAUSE, DONE.
- All outputs are registered. Reset values:
  - state = IDLE
  - cpu_rst_n = 0
  - cpu_clk_en = 0
  - busy = done = halted = timeout = 0
  - cycle_count = 0
- IDLE:
  - cpu_rst_n = 0, cpu_clk_en = 0.
  - start -> RST. On this transition: latch max_cycles and step_mode, clear cycle_count, halted, timeout and the stable counter.
- RST:
  - cpu_rst_n = 0 for exactly RESET_CYCLES cycles.
  - Then -> RUN (step_mode = 0) or PAUSE (step_mode = 1).
- RUN:
  - cpu_rst_n = 1, cpu_clk_en = 1 every cycle.
  - stop -> PAUSE.
  - Termination checks apply (below).
- PAUSE:
  - cpu_rst_n = 1, cpu_clk_en = 0.
  - resume -> RUN.
  - Otherwise step gives exactly one cycle with cpu_clk_en = 1 and stays in PAUSE. A step held high for n cycles gives n enabled cycles.
  - resume has priority over step. stop is ignored.
- DONE:
  - cpu_rst_n = 1, cpu_clk_en = 0; flags hold.
  - start -> RST (new run, flags cleared).
- start is ignored in RST/RUN/PAUSE. stop, resume and step are ignored outside their states.
- Cycle counting:
  - cycle_count increments on every cycle where cpu_clk_en = 1.
  - It saturates at all-ones.
- Halt detection (HALT_STABLE > 0):
  - On each enabled cycle, pc is compared with pc_last, the value captured at the previous enabled cycle of this run.
  - Equal: stable counter +1. Different: stable counter cleared. pc_last is updated every enabled cycle.
  - The first enabled cycle of a run only loads pc_last; no comparison.
  - When the stable counter reaches HALT_STABLE: halted = 1, -> DONE.
- Timeout:
  - When an enabled cycle brings cycle_count to the latched max_cycles (nonzero): timeout = 1, -> DONE.
- Halt and timeout on the same cycle: both flags set; single transition to DONE.
- A termination during a PAUSE step also -> DONE.
- rst_n asserted at any point: immediate return to reset values, including cpu_rst_n = 0 mid-run.

## Timing
- start sampled high at edge T:
  - state = RST from T+1; cpu_rst_n low through edge T+RESET_CYCLES.
  - cpu_rst_n = 1 and cpu_clk_en = 1 (free run) from T+RESET_CYCLES+1.
- stop at edge T in RUN: cpu_clk_en = 0 from T+1. The cycle containing edge T was still enabled and is counted.
- step at edge T in PAUSE: cpu_clk_en = 1 during T+1 only; cycle_count increments at T+1.
- Termination detected on the enabled cycle ending at edge T: done = 1 and cpu_clk_en = 0 from T+1.
- No enabled cycle follows a terminating one.
- busy and done are never high together.

## Test plan
- Budget: RESET_CYCLES=4, max_cycles=10, step_mode=0, pc incrementing each cycle, start pulse -> cpu_rst_n low exactly 4 cycles, exactly 10 cpu_clk_en cycles, done=1, timeout=1, halted=0, cycle_count=10.
- Halt: HALT_STABLE=8, max_cycles=0, pc increments 5 times then freezes at 0x0042 -> DONE after 8 frozen compares, halted=1, timeout=0.
- Single-step: step_mode=1, 3 isolated step pulses, then resume, then stop -> 3 single enabled cycles in PAUSE, free run after resume, PAUSE after stop, cycle_count exact.
- Simultaneous: max_cycles=9 with pc frozen from enabled cycle 1 (so stable count hits 8 on cycle 9) -> halted=1 and timeout=1 on the same transition to DONE.
- Restart and ignored inputs: start, resume and step pulsed during RUN have no effect; start in DONE clears flags and cycle_count and re-enters RST for 4 cycles.
- Async reset: assert rst_n low mid-RUN between clock edges -> cpu_rst_n=0, cpu_clk_en=0, all flags 0, state IDLE immediately, not at the next edge.

Source files
------------

// File: rtl/risc_run_ctrl.sv
// Run controller for the 16-bit RISC core: reset sequencing, clock gating,
// free-run / pause / single-step, and termination on cycle budget or stuck PC.
module risc_run_ctrl #(
    parameter int CYCLE_W      = 32,
    parameter int PC_W         = 16,
    parameter int RESET_CYCLES = 4,
    parameter int HALT_STABLE  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               resume,
    input  logic               step,
    input  logic               step_mode,
    input  logic [CYCLE_W-1:0] max_cycles,
    input  logic [PC_W-1:0]    pc,
    output logic               cpu_rst_n,
    output logic               cpu_clk_en,
    output logic               busy,
    output logic               done,
    output logic               halted,
    output logic               timeout,
    output logic [CYCLE_W-1:0] cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int SW = (HALT_STABLE > 0) ? $clog2(HALT_STABLE + 1) : 1;
    localparam logic [RW-1:0] RST_LAST   = RW'(RESET_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_LIM = SW'(HALT_STABLE);

    state_t             state, state_d;
    logic [RW-1:0]      rst_cnt, rst_cnt_d;
    logic [CYCLE_W-1:0] max_lat, max_d;
    logic               step_lat, step_d;
    logic [PC_W-1:0]    pc_last, pc_last_d;
    logic               pc_valid, pc_valid_d;
    logic [SW-1:0]      stable, stable_d;
    logic               cpu_rst_n_d, clk_en_d, busy_d, done_d, halted_d, timeout_d;
    logic [CYCLE_W-1:0] count_d;
    logic               hit_halt, hit_budget, term;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            rst_cnt     <= '0;
            max_lat     <= '0;
            step_lat    <= 1'b0;
            pc_last     <= '0;
            pc_valid    <= 1'b0;
            stable      <= '0;
            cpu_rst_n   <= 1'b0;
            cpu_clk_en  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            halted      <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
        end else begin
            state       <= state_d;
            rst_cnt     <= rst_cnt_d;
            max_lat     <= max_d;
            step_lat    <= step_d;
            pc_last     <= pc_last_d;
            pc_valid    <= pc_valid_d;
            stable      <= stable_d;
            cpu_rst_n   <= cpu_rst_n_d;
            cpu_clk_en  <= clk_en_d;
            busy        <= busy_d;
            done        <= done_d;
            halted      <= halted_d;
            timeout     <= timeout_d;
            cycle_count <= count_d;
        end
    end

    always_comb begin
        state_d     = state;
        rst_cnt_d   = rst_cnt;
        max_d       = max_lat;
        step_d      = step_lat;
        pc_last_d   = pc_last;
        pc_valid_d  = pc_valid;
        stable_d    = stable;
        cpu_rst_n_d = cpu_rst_n;
        clk_en_d    = cpu_clk_en;
        halted_d    = halted;
        timeout_d   = timeout;
        count_d     = cycle_count;
        hit_halt    = 1'b0;
        hit_budget  = 1'b0;

        // Bookkeeping happens at the edge that closes an enabled core cycle.
        if (cpu_clk_en) begin
            if (cycle_count != '1)
                count_d = cycle_count + 1'b1;
            hit_budget = (max_lat != '0) && (count_d == max_lat);
            pc_last_d  = pc;
            pc_valid_d = 1'b1;
            if ((HALT_STABLE > 0) && pc_valid) begin
                if (pc == pc_last) begin
                    stable_d = stable + 1'b1;
                    hit_halt = (stable_d == STABLE_LIM);
                end else begin
                    stable_d = '0;
                end
            end
        end
        term = hit_halt || hit_budget;

        if (term) begin
            state_d   = S_DONE;
            clk_en_d  = 1'b0;
            halted_d  = hit_halt;
            timeout_d = hit_budget;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d     = S_RST;
                        rst_cnt_d   = '0;
                        max_d       = max_cycles;
                        step_d      = step_mode;
                        count_d     = '0;
                        halted_d    = 1'b0;
                        timeout_d   = 1'b0;
                        stable_d    = '0;
                        pc_valid_d  = 1'b0;
                        cpu_rst_n_d = 1'b0;
                        clk_en_d    = 1'b0;
                    end
                end
                S_RST: begin
                    if (rst_cnt == RST_LAST) begin
                        state_d     = step_lat ? S_PAUSE : S_RUN;
                        cpu_rst_n_d = 1'b1;
                        clk_en_d    = !step_lat;
                    end else begin
                        rst_cnt_d = rst_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state_d  = S_PAUSE;
                        clk_en_d = 1'b0;
                    end else begin
                        clk_en_d = 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (resume) begin
                        state_d  = S_RUN;
                        clk_en_d = 1'b1;
                    end else begin
                        clk_en_d = step;
                    end
                end
                default: begin
                    state_d     = S_IDLE;
                    cpu_rst_n_d = 1'b0;
                    clk_en_d    = 1'b0;
                end
            endcase
        end

        busy_d = (state_d == S_RST) || (state_d == S_RUN) || (state_d == S_PAUSE);
        done_d = (state_d == S_DONE);
    end

endmodule

// File: tb/tb_risc_run_ctrl.sv
// Directed bench for risc_run_ctrl: a spec-level reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_risc_run_ctrl;
    localparam int CW = 32;
    localparam int PW = 16;
    localparam int RC = 4;
    localparam int HS = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0, stop = 1'b0, resume = 1'b0, step = 1'b0, step_mode = 1'b0;
    logic [CW-1:0] max_cycles = '0;
    logic [PW-1:0] pc = '0;
    logic          cpu_rst_n, cpu_clk_en, busy, done, halted, timeout;
    logic [CW-1:0] cycle_count;

    int errors = 0;
    int checks = 0;

    risc_run_ctrl #(.CYCLE_W(CW), .PC_W(PW), .RESET_CYCLES(RC), .HALT_STABLE(HS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .resume(resume),
        .step(step), .step_mode(step_mode), .max_cycles(max_cycles), .pc(pc),
        .cpu_rst_n(cpu_rst_n), .cpu_clk_en(cpu_clk_en), .busy(busy), .done(done),
        .halted(halted), .timeout(timeout), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {P_IDLE, P_RST, P_RUN, P_PAUSE, P_DONE} phase_t;
    phase_t        m_phase = P_IDLE;
    int            m_rst_left = 0;
    bit            m_sm = 1'b0;
    logic [CW-1:0] m_max = '0;
    logic [CW-1:0] m_cnt = '0;
    bit            m_rst_n = 1'b0, m_en = 1'b0, m_halt = 1'b0, m_tmo = 1'b0, m_term, m_same;
    logic [PW-1:0] m_hist[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = P_IDLE; m_rst_n = 0; m_en = 0; m_halt = 0; m_tmo = 0; m_cnt = '0;
            m_hist.delete();
        end else begin
            m_term = 0;
            if (m_en) begin
                if (m_cnt != '1) m_cnt++;
                // halt = the last HS+1 sampled PCs of this run are all identical
                m_hist.push_back(pc);
                if (m_hist.size() > HS + 1) void'(m_hist.pop_front());
                m_same = (HS > 0) && (m_hist.size() == HS + 1);
                foreach (m_hist[i]) if (m_hist[i] != m_hist[0]) m_same = 0;
                if (m_same) m_halt = 1;
                if (m_max != 0 && m_cnt == m_max) m_tmo = 1;
                m_term = m_halt || m_tmo;
            end
            if (m_term) begin
                m_phase = P_DONE; m_en = 0;
            end else begin
                case (m_phase)
                    P_IDLE, P_DONE: if (start) begin
                        m_phase = P_RST; m_rst_left = RC; m_max = max_cycles; m_sm = step_mode;
                        m_cnt = '0; m_halt = 0; m_tmo = 0; m_rst_n = 0; m_en = 0; m_hist.delete();
                    end
                    P_RST: begin
                        m_rst_left--;
                        if (m_rst_left == 0) begin
                            m_phase = m_sm ? P_PAUSE : P_RUN; m_rst_n = 1; m_en = !m_sm;
                        end
                    end
                    P_RUN: if (stop) begin m_phase = P_PAUSE; m_en = 0; end
                    P_PAUSE: if (resume) begin m_phase = P_RUN; m_en = 1; end else m_en = step;
                    default: ;
                endcase
            end
        end
    end

    wire m_busy = (m_phase == P_RST) || (m_phase == P_RUN) || (m_phase == P_PAUSE);
    wire m_done = (m_phase == P_DONE);

    always @(negedge clk)
        check("cycle_outputs",
              {cpu_rst_n, cpu_clk_en, busy, done, halted, timeout, cycle_count},
              {m_rst_n, m_en, m_busy, m_done, m_halt, m_tmo, m_cnt});

    // ---------------- pc stimulus and observation ----------------
    int pc_mode = 0;
    int k = 0;
    always @(negedge clk) begin
        if (!cpu_rst_n) k = 0;
        else if (cpu_clk_en) k++;
        case (pc_mode)
            1:       pc = 16'h003D + 16'((k > 6) ? 5 : ((k > 0) ? k - 1 : 0));
            2:       pc = 16'h0042;
            default: pc = 16'(k);
        endcase
    end

    int rst_obs = 0;
    int en_obs = 0;
    always @(negedge clk) begin
        if (busy && !cpu_rst_n) rst_obs++;
        if (cpu_clk_en) en_obs++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic run_start(input logic [CW-1:0] mx, input logic sm);
        start = 1; max_cycles = mx; step_mode = sm; rst_obs = 0; en_obs = 0;
        tick();
        start = 0; max_cycles = 32'hFFFF_FFF0; step_mode = ~sm;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int i = 0;
        while (!done && i < budget) begin tick(); i++; end
        check(tag, done, 1);
    endtask

    initial begin
        #1;
        check("reset_values", {cpu_rst_n, cpu_clk_en, busy, done, halted, timeout, cycle_count}, 0);
        tick(); tick();
        rst_n = 1;
        tick();

        // budget run
        pc_mode = 0;
        run_start(10, 0);
        wait_done(40, "budget_done");
        check("budget_rst_low", rst_obs, 4);
        check("budget_en_cycles", en_obs, 10);
        check("budget_count", cycle_count, 10);
        check("budget_flags", {halted, timeout}, 2'b01);
        repeat (3) tick();
        check("budget_no_extra_en", en_obs, 10);

        // halt on frozen pc
        pc_mode = 1;
        run_start(0, 0);
        wait_done(60, "halt_done");
        check("halt_count", cycle_count, 14);
        check("halt_en_cycles", en_obs, 14);
        check("halt_flags", {halted, timeout}, 2'b10);

        // single-step, resume, stop
        pc_mode = 0;
        run_start(0, 1);
        repeat (6) tick();
        check("pause_no_en", en_obs, 0);
        stop = 1; tick(); stop = 0; tick();
        for (int i = 0; i < 3; i++) begin
            step = 1; tick(); step = 0; tick(); tick();
        end
        check("step_en_cycles", en_obs, 3);
        resume = 1; tick(); resume = 0;
        repeat (4) tick();
        stop = 1; tick(); stop = 0;
        repeat (3) tick();
        check("stop_count", cycle_count, 8);
        check("stop_paused", {busy, done, cpu_clk_en, cpu_rst_n}, 4'b1001);
        step = 1; tick(); tick(); step = 0; tick();
        check("step_held_en", en_obs, 10);

        // async reset mid-run
        resume = 1; tick(); resume = 0;
        repeat (5) tick();
        #2 rst_n = 0;
        #1;
        check("async_reset", {cpu_rst_n, cpu_clk_en, busy, done, halted, timeout, cycle_count}, 0);
        tick(); tick();
        rst_n = 1;
        tick();

        // simultaneous halt and timeout
        pc_mode = 2;
        run_start(9, 0);
        wait_done(40, "simul_done");
        check("simul_count", cycle_count, 9);
        check("simul_flags", {halted, timeout}, 2'b11);

        // ignored inputs during RUN, then restart from DONE
        pc_mode = 0;
        run_start(20, 0);
        repeat (8) tick();
        start = 1; resume = 1; step = 1; tick();
        start = 0; resume = 0; step = 0;
        wait_done(60, "ignore_done");
        check("ignore_count", cycle_count, 20);
        check("ignore_en_cycles", en_obs, 20);
        run_start(5, 0);
        check("restart_cleared", {cpu_rst_n, busy, done, halted, timeout, cycle_count}, {5'b01000, 32'd0});
        wait_done(40, "restart_done");
        check("restart_rst_low", rst_obs, 4);
        check("restart_count", cycle_count, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end
endmodule
